// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, multiplier FSM encoding, default width
// and the signed add/sub overflow rule used by the EX-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] AND_OP = 4'd0;
    localparam logic [ALU_OP_W-1:0] OR_OP  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ADD_OP = 4'd2;
    localparam logic [ALU_OP_W-1:0] SLL_OP = 4'd3;
    localparam logic [ALU_OP_W-1:0] SRL_OP = 4'd4;
    localparam logic [ALU_OP_W-1:0] SUB_OP = 4'd5;
    localparam logic [ALU_OP_W-1:0] SLT_OP = 4'd7;
    localparam logic [ALU_OP_W-1:0] NOR_OP = 4'd12;
    localparam logic [ALU_OP_W-1:0] MUL_OP = 4'd13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // ADD overflows on like-signed operands, SUB on unlike-signed; either way the result flips sign vs A.
    function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                         input logic r_msb, input logic is_sub);
        return ((a_msb ^ b_msb) == is_sub) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, keeps the low DATA_W bits.
// Sequencing (start/step/abort) is driven by the owning FSM in alu_exec.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_c_o,
    output logic [DATA_W-1:0] product_c_o
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_next_c;

    assign acc_next_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_next_c;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // The final step's sum is the product; the owner registers it on the same edge.
    assign done_c_o    = step_i && (cnt_q == CNT_LAST);
    assign product_c_o = acc_next_c;

endmodule

// File: rtl/alu_exec.sv
// EX-stage ALU: single-cycle logic/arith/shift ops with registered result and flags.
// Define ALU_EXEC_MUL_EN to add the iterative multiplier, its FSM and the busy stall.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               valid_in,
    input  logic [3:0]         alu_control,
    input  logic [DATA_W-1:0]  alu_in_0,
    input  logic [DATA_W-1:0]  alu_in_1,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic [DATA_W-1:0]  alu_out,
    output logic               zero,
    output logic               overflow,
    output logic               valid_out,
    output logic               busy
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] out_q, out_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;

    logic              accept_c;
    logic              is_mul_c;
    logic              mul_done_c;
    logic [DATA_W-1:0] mul_prod_c;
    logic [DATA_W-1:0] sum_c, diff_c, res_c;
    logic              ovf_c;

    assign accept_c = valid_in && !busy_q && !flush;
    assign sum_c    = alu_in_0 + alu_in_1;
    assign diff_c   = alu_in_0 - alu_in_1;

    // Single-cycle op mux; unknown codes (and MUL when the multiplier is absent) yield 0.
    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        case (alu_control)
            AND_OP: res_c = alu_in_0 & alu_in_1;
            OR_OP:  res_c = alu_in_0 | alu_in_1;
            NOR_OP: res_c = ~(alu_in_0 | alu_in_1);
            ADD_OP: begin
                res_c = sum_c;
                ovf_c = add_sub_ovf(alu_in_0[MSB], alu_in_1[MSB], sum_c[MSB], 1'b0);
            end
            SUB_OP: begin
                res_c = diff_c;
                ovf_c = add_sub_ovf(alu_in_0[MSB], alu_in_1[MSB], diff_c[MSB], 1'b1);
            end
            SLT_OP: res_c = DATA_W'($signed(alu_in_0) < $signed(alu_in_1));
            SLL_OP: res_c = alu_in_1 << shamt;
            SRL_OP: res_c = alu_in_1 >> shamt;
            default: begin
                res_c = '0;
                ovf_c = 1'b0;
            end
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    alu_state_e state_q, state_d;
    logic       mul_start_c;
    logic       mul_step_c;

    assign is_mul_c = (alu_control == MUL_OP);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush beats both a pending issue and the multiplier's final step.
    always_comb begin
        state_d     = state_q;
        mul_start_c = 1'b0;
        mul_step_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && is_mul_c) begin
                    state_d     = ST_MUL;
                    mul_start_c = 1'b1;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    mul_step_c = 1'b1;
                    if (mul_done_c) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    alu_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk         (clk),
        .arst_n      (arst_n),
        .start_i     (mul_start_c),
        .step_i      (mul_step_c),
        .abort_i     (flush),
        .a_i         (alu_in_0),
        .b_i         (alu_in_1),
        .done_c_o    (mul_done_c),
        .product_c_o (mul_prod_c)
    );

    assign busy_d = (state_d == ST_MUL);
`else
    assign is_mul_c   = 1'b0;
    assign mul_done_c = 1'b0;
    assign mul_prod_c = '0;
    assign busy_d     = 1'b0;
`endif

    // Result/flag write arbitration: a finishing multiply and an accepted issue never coincide.
    always_comb begin
        out_d  = out_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        vld_d  = 1'b0;
        if (mul_done_c) begin
            out_d  = mul_prod_c;
            zero_d = (mul_prod_c == '0);
            ovf_d  = 1'b0;
            vld_d  = 1'b1;
        end else if (accept_c && !is_mul_c) begin
            out_d  = res_c;
            zero_d = (res_c == '0);
            ovf_d  = ovf_c;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
            busy_q <= busy_d;
        end
    end

    assign alu_out   = out_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign valid_out = vld_q;
    assign busy      = busy_q;

endmodule
